// File: rtl/axis_merge.sv
// Many-to-one AXI-Stream merger: round-robin arbitration across NM slave ports,
// optional grant lock for a whole packet, and a registered master output stage.
module axis_merge #(
    parameter int C_AXIS_DATA_WIDTH = 16,
    parameter int NM                = 4,
    parameter bit OPT_LOCK          = 1'b1
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [NM-1:0]                   S_AXIS_TVALID,
    output logic [NM-1:0]                   S_AXIS_TREADY,
    input  logic [NM*C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [NM-1:0]                   S_AXIS_TLAST,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic                            M_AXIS_TLAST,
    output logic [$clog2(NM)-1:0]           M_AXIS_TID
);
    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int IW = $clog2(NM);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [IW-1:0] grant_q, grant_d;
    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          m_last_q, m_last_d;
    logic [IW-1:0] m_id_q, m_id_d;

    logic          out_free;
    logic          any_valid;
    logic          accept;
    logic [IW-1:0] rr_pick;
    logic [IW-1:0] sel;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
        return IW'((32'(base) + off) % NM);
    endfunction

    assign out_free  = !m_valid_q || M_AXIS_TREADY;
    assign any_valid = |S_AXIS_TVALID;

    // Walk from the farthest offset down so the port nearest after last_grant wins.
    always_comb begin
        rr_pick = last_grant_q;
        for (int i = NM; i >= 1; i--) begin
            if (S_AXIS_TVALID[wrap_add(last_grant_q, i)]) rr_pick = wrap_add(last_grant_q, i);
        end
    end

    assign sel = (state_q == LOCKED) ? grant_q : rr_pick;

    // NOTE: every signal written in an always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        S_AXIS_TREADY = '0;
        if (S_AXI_ARESETN && out_free) begin
            if (state_q == LOCKED)  S_AXIS_TREADY[grant_q] = 1'b1;
            else if (any_valid)     S_AXIS_TREADY[rr_pick] = 1'b1;
        end
    end

    assign accept = |(S_AXIS_TREADY & S_AXIS_TVALID);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        m_id_d       = m_id_q;
        if (accept) begin
            m_valid_d    = 1'b1;
            m_data_d     = S_AXIS_TDATA[sel*DW +: DW];
            m_last_d     = S_AXIS_TLAST[sel];
            m_id_d       = sel;
            last_grant_d = sel;
            grant_d      = sel;
            state_d      = (S_AXIS_TLAST[sel] || !OPT_LOCK) ? IDLE : LOCKED;
        end else if (M_AXIS_TREADY) begin
            m_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NM - 1);
            grant_q      <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            m_id_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            m_id_q       <= m_id_d;
        end
    end

    assign M_AXIS_TVALID = m_valid_q;
    assign M_AXIS_TDATA  = m_data_q;
    assign M_AXIS_TLAST  = m_last_q;
    assign M_AXIS_TID    = m_id_q;

endmodule

// File: tb/tb_axis_merge.sv
// Bench for axis_merge: a locked and an unlocked instance driven from per-port
// beat queues, compared every cycle against a behavioural arbitration model.
`timescale 1ns/1ps
module tb_axis_merge;
    localparam int DW = 16;
    localparam int NM = 4;
    localparam int IW = $clog2(NM);

    typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct packed { logic valid; logic [DW-1:0] data; logic last; logic [IW-1:0] id; } mout_t;
    typedef struct { int id; logic [DW-1:0] data; logic last; int cyc; } xfer_t;

    logic clk = 1'b0;
    logic rstn;
    logic [NM-1:0]    s_valid [2];
    logic [NM-1:0]    s_last  [2];
    logic [NM*DW-1:0] s_data  [2];
    logic             m_ready [2];
    logic [NM-1:0]    sr0, sr1;
    logic             mv0, mv1, ml0, ml1;
    logic [DW-1:0]    md0, md1;
    logic [IW-1:0]    mi0, mi1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int unsigned gate_pct = 100;

    beat_t src_q   [2][NM][$];
    bit    present [2][NM];
    xfer_t obs_q   [2][$];
    int            e_id [$];
    logic [DW-1:0] e_d  [$];

    // Reference model state, one set per instance (0: locked, 1: unlocked).
    mout_t exp_out    [2];
    bit    locked     [2];
    int    lock_port  [2];
    int    last_grant [2];

    always #5 clk = ~clk;

    axis_merge #(.C_AXIS_DATA_WIDTH(DW), .NM(NM), .OPT_LOCK(1'b1)) dut_lock (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
        .S_AXIS_TVALID(s_valid[0]), .S_AXIS_TREADY(sr0), .S_AXIS_TDATA(s_data[0]), .S_AXIS_TLAST(s_last[0]),
        .M_AXIS_TVALID(mv0), .M_AXIS_TREADY(m_ready[0]), .M_AXIS_TDATA(md0), .M_AXIS_TLAST(ml0), .M_AXIS_TID(mi0)
    );

    axis_merge #(.C_AXIS_DATA_WIDTH(DW), .NM(NM), .OPT_LOCK(1'b0)) dut_nolock (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
        .S_AXIS_TVALID(s_valid[1]), .S_AXIS_TREADY(sr1), .S_AXIS_TDATA(s_data[1]), .S_AXIS_TLAST(s_last[1]),
        .M_AXIS_TVALID(mv1), .M_AXIS_TREADY(m_ready[1]), .M_AXIS_TDATA(md1), .M_AXIS_TLAST(ml1), .M_AXIS_TID(mi1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NM-1:0] dut_ready(input int u);
        return (u == 0) ? sr0 : sr1;
    endfunction

    function automatic mout_t dut_out(input int u);
        return (u == 0) ? {mv0, md0, ml0, mi0} : {mv1, md1, ml1, mi1};
    endfunction

    function automatic void model_reset(input int u);
        exp_out[u]    = '0;
        locked[u]     = 1'b0;
        lock_port[u]  = 0;
        last_grant[u] = NM - 1;
    endfunction

    // Which port the merger should be offering ready to, from the arbitration rules.
    function automatic logic [NM-1:0] model_ready(input int u);
        logic [NM-1:0] r;
        int idx;
        r = '0;
        if (!rstn || (exp_out[u].valid && !m_ready[u])) return r;
        if (locked[u]) begin
            r[lock_port[u]] = 1'b1;
            return r;
        end
        for (int i = 1; i <= NM; i++) begin
            idx = (last_grant[u] + i) % NM;
            if (s_valid[u][idx]) begin
                r[idx] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic void model_edge(input int u, input logic [NM-1:0] acc);
        if (!rstn) begin
            model_reset(u);
            return;
        end
        for (int g = 0; g < NM; g++) begin
            if (acc[g]) begin
                exp_out[u].valid = 1'b1;
                exp_out[u].data  = s_data[u][g*DW +: DW];
                exp_out[u].last  = s_last[u][g];
                exp_out[u].id    = IW'(g);
                last_grant[u]    = g;
                lock_port[u]     = g;
                locked[u]        = (u == 0) && !s_last[u][g];
                return;
            end
        end
        if (m_ready[u]) exp_out[u].valid = 1'b0;
    endfunction

    task automatic push_beat(input int u, input int k, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[u][k].push_back(b);
    endtask

    task automatic expect_beat(input int id, input logic [DW-1:0] d);
        e_id.push_back(id);
        e_d.push_back(d);
    endtask

    // Present queued beats; a presented beat stays put until it is accepted.
    task automatic drive();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < NM; k++) begin
                if (!present[u][k] && src_q[u][k].size() > 0 && $urandom_range(99) < gate_pct)
                    present[u][k] = 1'b1;
                s_valid[u][k] = present[u][k];
                if (present[u][k]) begin
                    s_data[u][k*DW +: DW] = src_q[u][k][0].data;
                    s_last[u][k]          = src_q[u][k][0].last;
                end else begin
                    s_data[u][k*DW +: DW] = DW'($urandom);
                    s_last[u][k]          = 1'($urandom);
                end
            end
        end
    endtask

    // One clock: check ready, log transfers, advance model, check registered outputs.
    task automatic step();
        logic [NM-1:0] er [2];
        logic [NM-1:0] acc;
        mout_t o;
        xfer_t x;
        #1;
        for (int u = 0; u < 2; u++) begin
            er[u] = model_ready(u);
            check($sformatf("u%0d s_tready", u), dut_ready(u), er[u]);
            o = dut_out(u);
            if (o.valid && m_ready[u]) begin
                x.id = int'(o.id); x.data = o.data; x.last = o.last; x.cyc = cyc;
                obs_q[u].push_back(x);
            end
        end
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            acc = er[u] & s_valid[u];
            model_edge(u, acc);
            for (int k = 0; k < NM; k++) begin
                if (acc[k]) begin
                    void'(src_q[u][k].pop_front());
                    present[u][k] = 1'b0;
                end
            end
        end
        cyc++;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            o = dut_out(u);
            check($sformatf("u%0d m_tvalid", u), o.valid, exp_out[u].valid);
            if (exp_out[u].valid) begin
                check($sformatf("u%0d m_tdata", u), o.data, exp_out[u].data);
                check($sformatf("u%0d m_tlast", u), o.last, exp_out[u].last);
                check($sformatf("u%0d m_tid", u), o.id, exp_out[u].id);
            end
        end
    endtask

    function automatic bit is_busy();
        for (int u = 0; u < 2; u++) begin
            if (exp_out[u].valid) return 1'b1;
            for (int k = 0; k < NM; k++) if (src_q[u][k].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drain(input string tag, input bit rand_ready);
        for (int n = 0; n < 4000 && is_busy(); n++) begin
            for (int u = 0; u < 2; u++) m_ready[u] = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
            step();
            drive();
        end
        check({tag, " drained"}, is_busy(), 1'b0);
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
    endtask

    task automatic compare_obs(input string tag, input int u);
        xfer_t x;
        check({tag, " beat count"}, obs_q[u].size(), e_id.size());
        for (int i = 0; i < e_id.size() && i < obs_q[u].size(); i++) begin
            x = obs_q[u][i];
            check($sformatf("%s tid[%0d]", tag, i), x.id, e_id[i]);
            check($sformatf("%s tdata[%0d]", tag, i), x.data, e_d[i]);
        end
        e_id.delete();
        e_d.delete();
    endtask

    initial begin
        xfer_t x;
        int gen [2];
        int n;
        rstn = 1'b0;
        for (int u = 0; u < 2; u++) begin
            m_ready[u] = 1'b1;
            s_valid[u] = '0;
            s_last[u]  = '0;
            s_data[u]  = '0;
            model_reset(u);
            gen[u] = 0;
        end
        @(negedge clk);

        // Reset held with every port valid.
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NM; k++) push_beat(0, k, DW'(16'h2000 + 16 * r + k), 1'b1);
        drive();
        repeat (4) begin
            step();
            drive();
            #1;
            check("reset m_tvalid", mv0, 1'b0);
            check("reset s_tready", sr0, '0);
            check("reset m_tid", mi0, '0);
        end

        // Fairness: single-beat packets from all ports rotate 0,1,2,3.
        rstn = 1'b1;
        obs_q[0].delete();
        drain("fairness", 1'b0);
        check("fairness beat count", obs_q[0].size(), 2 * NM);
        for (int i = 0; i < obs_q[0].size() && i < 2 * NM; i++) begin
            x = obs_q[0][i];
            check($sformatf("fairness tid[%0d]", i), x.id, i % NM);
            check($sformatf("fairness tdata[%0d]", i), x.data, 16'h2000 + 16 * (i / NM) + (i % NM));
            check($sformatf("fairness cycle[%0d]", i), x.cyc, obs_q[0][0].cyc + i);
        end

        // Packet lock: port 0 arrives mid-packet and waits for port 2's TLAST.
        obs_q[0].delete();
        push_beat(0, 2, 16'hA0A0, 1'b0);
        push_beat(0, 2, 16'hA0A1, 1'b0);
        push_beat(0, 2, 16'hA0A2, 1'b1);
        drive();
        step();
        push_beat(0, 0, 16'hB000, 1'b1);
        drive();
        drain("lock", 1'b0);
        expect_beat(2, 16'hA0A0); expect_beat(2, 16'hA0A1); expect_beat(2, 16'hA0A2); expect_beat(0, 16'hB000);
        compare_obs("lock", 0);

        // Backpressure for 5 clocks while 16'h1234 sits in the output register.
        obs_q[0].delete();
        push_beat(0, 1, 16'h1111, 1'b0);
        push_beat(0, 1, 16'h1234, 1'b0);
        push_beat(0, 1, 16'h5678, 1'b1);
        push_beat(0, 0, 16'h0F00, 1'b1);
        push_beat(0, 3, 16'h3F00, 1'b1);
        drive();
        step();
        drive();
        step();
        drive();
        m_ready[0] = 1'b0;
        repeat (5) begin
            step();
            drive();
            #1;
            check("stall m_tvalid", mv0, 1'b1);
            check("stall m_tdata", md0, 16'h1234);
            check("stall s_tready", sr0, '0);
        end
        m_ready[0] = 1'b1;
        drain("backpressure", 1'b0);
        expect_beat(1, 16'h1111); expect_beat(1, 16'h1234); expect_beat(1, 16'h5678);
        expect_beat(3, 16'h3F00); expect_beat(0, 16'h0F00);
        compare_obs("backpressure", 0);

        // Unlocked instance: two 2-beat packets interleave beat by beat.
        obs_q[1].delete();
        push_beat(1, 1, 16'hD100, 1'b0);
        push_beat(1, 1, 16'hD101, 1'b1);
        push_beat(1, 3, 16'hD300, 1'b0);
        push_beat(1, 3, 16'hD301, 1'b1);
        drive();
        drain("no lock", 1'b0);
        expect_beat(1, 16'hD100); expect_beat(3, 16'hD300); expect_beat(1, 16'hD101); expect_beat(3, 16'hD301);
        compare_obs("no lock", 1);

        // Reset after the first beat of a port-1 packet; port 0 wins afterwards.
        push_beat(0, 1, 16'hE100, 1'b0);
        push_beat(0, 1, 16'hE101, 1'b0);
        push_beat(0, 1, 16'hE102, 1'b1);
        drive();
        step();
        drive();
        rstn = 1'b0;
        step();
        drive();
        #1;
        check("mid reset m_tvalid", mv0, 1'b0);
        check("mid reset s_tready", sr0, '0);
        push_beat(0, 0, 16'hF000, 1'b1);
        rstn = 1'b1;
        obs_q[0].delete();
        drive();
        drain("mid reset", 1'b0);
        expect_beat(0, 16'hF000); expect_beat(1, 16'hE101); expect_beat(1, 16'hE102);
        compare_obs("mid reset", 0);

        // Randomized traffic on both instances with random valid gaps and stalls.
        gate_pct = 60;
        obs_q[0].delete();
        obs_q[1].delete();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < NM; k++) begin
                for (int p = 0; p < 3; p++) begin
                    n = int'($urandom_range(4, 1));
                    for (int i = 0; i < n; i++) push_beat(u, k, DW'($urandom), i == n - 1);
                    gen[u] += n;
                end
            end
        end
        drive();
        drain("random", 1'b1);
        check("random u0 beat count", obs_q[0].size(), gen[0]);
        check("random u1 beat count", obs_q[1].size(), gen[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
